// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-bus bridge:
// FSM state encoding, default opcodes, ACK byte and timeout defaults.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        TX_REQ,
        TX_WAIT
    } state_e;

    localparam logic [7:0] OP_WRITE_DEF = 8'hA5;
    localparam logic [7:0] OP_READ_DEF  = 8'h5A;
    localparam logic [7:0] ACK_BYTE     = 8'h06;

    localparam int unsigned TIMEOUT_DEF = 520700;
    localparam int unsigned TO_W_DEF    = 20;

endpackage

// File: rtl/uart_bridge_timeout.sv
// Inter-byte timeout counter for the bridge frame parser.
// Ports: clk, rst_n (async low), clr_i (restart count), en_i (count while
// a frame is partially received), expire_o (1-cycle pulse at TIMEOUT idle
// clocks). TIMEOUT=0 disables expiry entirely.
module uart_bridge_timeout
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST =
        TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic ACTIVE = (TIMEOUT != 0);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            hit;

    assign hit      = ACTIVE && en_i && (cnt_q == LAST);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign expire_o = hit && !clr_i;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || hit || !ACTIVE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART byte-stream to req/ack bus master bridge.
// Frames: write {OP_WRITE,addr,data}; read {OP_READ,addr} -> reply {rdata}.
// Ports: rx_finish/rx_data from UART receiver, tx_busy/tx_start/tx_data to
// UART sender, bus_req/bus_we/bus_addr/bus_wdata/bus_rdata/bus_ack bus
// master, frame_err pulse on bad opcode or inter-byte timeout.
// Macro UART_BRIDGE_WRITE_ACK_EN: reply one ACK byte after each write.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0]  OP_WRITE = OP_WRITE_DEF,
    parameter logic [7:0]  OP_READ  = OP_READ_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned TO_W     = TO_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_finish,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       frame_err
);

    state_e     state_q, state_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       bus_req_q, bus_req_d;
    logic       tx_start_q, tx_start_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_seen_q, busy_seen_d;
    logic       to_en;
    logic       to_expire;

    assign to_en = (state_q == ADDR) || (state_q == DATA);

    uart_bridge_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (rx_finish),
        .en_i     (to_en),
        .expire_o (to_expire)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tx_data_d   = tx_data_q;
        bus_req_d   = bus_req_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_seen_d = busy_seen_q;
        unique case (state_q)
            IDLE: begin
                if (rx_finish) begin
                    if (rx_data == OP_WRITE) begin
                        we_d    = 1'b1;
                        state_d = ADDR;
                    end else if (rx_data == OP_READ) begin
                        we_d    = 1'b0;
                        state_d = ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_finish) begin
                    addr_d = rx_data;
                    if (we_q) begin
                        state_d = DATA;
                    end else begin
                        bus_req_d = 1'b1;
                        state_d   = BUS;
                    end
                end else if (to_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DATA: begin
                if (rx_finish) begin
                    wdata_d   = rx_data;
                    bus_req_d = 1'b1;
                    state_d   = BUS;
                end else if (to_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (we_q) begin
`ifdef UART_BRIDGE_WRITE_ACK_EN
                        tx_data_d = ACK_BYTE;
                        state_d   = TX_REQ;
`else
                        state_d   = IDLE;
`endif
                    end else begin
                        tx_data_d = bus_rdata;
                        state_d   = TX_REQ;
                    end
                end
            end
            TX_REQ: begin
                if (!tx_busy) begin
                    tx_start_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // Done only after the sender has gone busy and dropped again.
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_data_q   <= '0;
            bus_req_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_data_q   <= tx_data_d;
            bus_req_q   <= bus_req_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed scoreboard bench for uart_bus_bridge (TIMEOUT=100).
// Expected bus transactions and reply bytes are queued when frames are sent.
module tb_uart_bus_bridge;
    import uart_bridge_pkg::*;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_finish;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       frame_err;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    int         total = 0;
    int         bad   = 0;

    uart_bus_bridge #(
        .TIMEOUT (TO),
        .TO_W    (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_finish (rx_finish),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data   = b;
        rx_finish = 1'b1;
        @(negedge clk);
        rx_finish = 1'b0;
    endtask

    task automatic serve_bus(input logic [7:0] rdata);
        int   n = 0;
        bus_t e;
        while (bus_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bus_req_seen", bus_req, 1);
        chk("sb_bus_nonempty", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            chk("bus_we", bus_we, e.we);
            chk("bus_addr", bus_addr, e.addr);
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        end
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
        chk("bus_req_drop", bus_req, 0);
    endtask

    task automatic serve_tx(output int lat, output logic [7:0] b);
        lat = 0;
        b   = 8'h00;
        while (tx_start !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("tx_start_seen", tx_start, 1);
        chk("sb_tx_nonempty", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
            b = exp_tx.pop_front();
            chk("tx_data", tx_data, b);
        end
    endtask

    task automatic finish_tx(input int hold, input logic [7:0] b);
        int extra = 0;
        tx_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0) extra++;
            chk("tx_data_stable", tx_data, b);
        end
        chk("tx_start_once", extra, 0);
        tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic post_write();
`ifdef UART_BRIDGE_WRITE_ACK_EN
        int         lat;
        logic [7:0] b;
        serve_tx(lat, b);
        chk("ack_latency", lat, 1);
        finish_tx(2, b);
`else
        int cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0) cnt++;
        end
        chk("no_reply_on_write", cnt, 0);
`endif
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_bus.push_back('{1'b1, a, d});
`ifdef UART_BRIDGE_WRITE_ACK_EN
        exp_tx.push_back(ACK_BYTE);
`endif
        send_byte(OP_WRITE_DEF);
        send_byte(a);
        send_byte(d);
        chk("wr_req_latency", bus_req, 1);
        serve_bus(8'h00);
        post_write();
    endtask

    initial begin
        int         n;
        int         lat;
        int         early;
        logic [7:0] b;

        rst_n     = 1'b0;
        rx_finish = 1'b0;
        rx_data   = 8'h00;
        tx_busy   = 1'b0;
        bus_rdata = 8'h00;
        bus_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_outs", {bus_we, bus_addr, bus_wdata, tx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_write(8'h10, 8'h3C);

        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_ack_req", bus_req, 0);
        @(negedge clk);
        chk("stray_ack_tx", tx_start, 0);

        exp_bus.push_back('{1'b0, 8'h22, 8'h00});
        exp_tx.push_back(8'hC7);
        send_byte(OP_READ_DEF);
        send_byte(8'h22);
        chk("rd_req_latency", bus_req, 1);
        serve_bus(8'hC7);
        serve_tx(lat, b);
        chk("rd_tx_latency", lat, 1);
        tx_busy = 1'b1;
        send_byte(8'h00);
        chk("drop_no_err", frame_err, 0);
        send_byte(OP_WRITE_DEF);
        chk("drop_tx_data", tx_data, 8'hC7);
        finish_tx(3, b);
        chk("drop_no_req", bus_req, 0);

        send_byte(8'h00);
        chk("badop_err", frame_err, 1);
        chk("badop_no_req", bus_req, 0);
        @(negedge clk);
        chk("badop_err_pulse", frame_err, 0);
        do_write(8'h01, 8'h02);

        send_byte(OP_WRITE_DEF);
        n = 0;
        while (frame_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TO);
        @(negedge clk);
        send_byte(8'h10);
        chk("post_to_opcode_err", frame_err, 1);
        chk("post_to_no_req", bus_req, 0);

        exp_bus.push_back('{1'b1, 8'h77, 8'h88});
`ifdef UART_BRIDGE_WRITE_ACK_EN
        exp_tx.push_back(ACK_BYTE);
`endif
        send_byte(OP_WRITE_DEF);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h77);
        chk("byte_wins_no_err", frame_err, 0);
        send_byte(8'h88);
        chk("byte_wins_req", bus_req, 1);
        serve_bus(8'h00);
        post_write();

        exp_bus.push_back('{1'b0, 8'h44, 8'h00});
        exp_tx.push_back(8'h9E);
        send_byte(OP_READ_DEF);
        send_byte(8'h44);
        tx_busy = 1'b1;
        serve_bus(8'h9E);
        early = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0) early++;
        end
        chk("busy_no_early_start", early, 0);
        tx_busy = 1'b0;
        serve_tx(lat, b);
        chk("busy_start_latency", lat, 1);
        finish_tx(4, b);

        send_byte(OP_WRITE_DEF);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("pre_reset_req", bus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", bus_req, 0);
        chk("async_rst_tx", tx_start, 0);
        chk("async_rst_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_write(8'h05, 8'h06);

        chk("sb_bus_drained", exp_bus.size(), 0);
        chk("sb_tx_drained", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
